writeback: RTL and testbench

Final pipeline stage of the processor, directly downstream of the memory stage. Selects the register-file write value (ALU result, PC+4, or loaded data). Load data is byte/halfword extracted and sign/zero-extended using the memory stage's funct3 and byte offset. Drives the register-file write port, keeps a one-cycle late-forwarding register, runs a halt state machine and holds optional performance counters.

---
 rtl/writeback.sv | 108 ++++++++++
 tb/tb_writeback.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Writeback stage: load extraction, result mux, late-forwarding register and halt FSM.
// Optional performance counters are built only when WB_PERF_CNT_EN is defined.
module writeback #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALU_out_MEMWB,
  input  logic [WIDTH-1:0] pc_4_MEMWB,
  input  logic [WIDTH-1:0] mem_rd_data_MEMWB,
  input  logic [1:0]       reg_wr_ctrl_MEMWB,
  input  logic [2:0]       funct3_MEMWB,
  input  logic [1:0]       byte_offset_MEMWB,
  input  logic [4:0]       rd_MEMWB,
  input  logic             reg_wr_en_MEMWB,
  input  logic             halt_WB,
  output logic [WIDTH-1:0] reg_wr_data_WBID,
  output logic [4:0]       rd_WBID,
  output logic             reg_wr_en_WBID,
  output logic [WIDTH-1:0] fwd_data_WB,
  output logic [4:0]       fwd_rd_WB,
  output logic             fwd_valid_WB,
  output logic             halted,
  output logic [31:0]      wr_count,
  output logic [31:0]      cycle_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state;
  logic [WIDTH-1:0] byte_word;
  logic [WIDTH-1:0] half_word;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] mux_data;
  logic             eff_wr;

  always_comb begin
    byte_word = mem_rd_data_MEMWB >> {byte_offset_MEMWB, 3'b000};
    half_word = mem_rd_data_MEMWB >> {byte_offset_MEMWB[1], 4'b0000};
    case (funct3_MEMWB)
      3'b000:  load_data = {{(WIDTH-8){byte_word[7]}}, byte_word[7:0]};
      3'b001:  load_data = {{(WIDTH-16){half_word[15]}}, half_word[15:0]};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_word[7:0]};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_word[15:0]};
      default: load_data = mem_rd_data_MEMWB;
    endcase
  end

  always_comb begin
    case (reg_wr_ctrl_MEMWB)
      2'd0:    mux_data = ALU_out_MEMWB;
      2'd1:    mux_data = pc_4_MEMWB;
      2'd2:    mux_data = load_data;
      default: mux_data = '0;
    endcase
  end

  // The reset term keeps the register file from capturing anything while reset is held.
  assign eff_wr = reg_wr_en_MEMWB & (rd_MEMWB != 5'd0) & (state == RUN) & reset;

  assign reg_wr_data_WBID = mux_data;
  assign rd_WBID          = rd_MEMWB;
  assign reg_wr_en_WBID   = eff_wr;
  assign halted           = (state == HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      fwd_data_WB  <= '0;
      fwd_rd_WB    <= '0;
      fwd_valid_WB <= 1'b0;
    end else begin
      if (eff_wr) begin
        fwd_data_WB  <= mux_data;
        fwd_rd_WB    <= rd_MEMWB;
        fwd_valid_WB <= 1'b1;
      end else begin
        fwd_valid_WB <= 1'b0;
      end
      case (state)
        RUN:     if (halt_WB) state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] wr_cnt_q;
  logic [31:0] cyc_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q  <= '0;
      cyc_cnt_q <= '0;
    end else if (state == RUN) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (eff_wr) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign wr_count    = wr_cnt_q;
  assign cycle_count = cyc_cnt_q;
`else
  assign wr_count    = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: load extraction, source mux, forwarding, halt and reset.
// Counter expectations follow WB_PERF_CNT_EN (zero when the macro is undefined).
module tb_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] ALU_out_MEMWB;
  logic [31:0] pc_4_MEMWB;
  logic [31:0] mem_rd_data_MEMWB;
  logic [1:0]  reg_wr_ctrl_MEMWB;
  logic [2:0]  funct3_MEMWB;
  logic [1:0]  byte_offset_MEMWB;
  logic [4:0]  rd_MEMWB;
  logic        reg_wr_en_MEMWB;
  logic        halt_WB;
  logic [31:0] reg_wr_data_WBID;
  logic [4:0]  rd_WBID;
  logic        reg_wr_en_WBID;
  logic [31:0] fwd_data_WB;
  logic [4:0]  fwd_rd_WB;
  logic        fwd_valid_WB;
  logic        halted;
  logic [31:0] wr_count;
  logic [31:0] cycle_count;

  int          total;
  int          bad;
  logic [31:0] exp_wr;
  logic [31:0] exp_cyc;
  bit          model_halted;

  writeback dut (
    .clk               (clk),
    .reset             (reset),
    .ALU_out_MEMWB     (ALU_out_MEMWB),
    .pc_4_MEMWB        (pc_4_MEMWB),
    .mem_rd_data_MEMWB (mem_rd_data_MEMWB),
    .reg_wr_ctrl_MEMWB (reg_wr_ctrl_MEMWB),
    .funct3_MEMWB      (funct3_MEMWB),
    .byte_offset_MEMWB (byte_offset_MEMWB),
    .rd_MEMWB          (rd_MEMWB),
    .reg_wr_en_MEMWB   (reg_wr_en_MEMWB),
    .halt_WB           (halt_WB),
    .reg_wr_data_WBID  (reg_wr_data_WBID),
    .rd_WBID           (rd_WBID),
    .reg_wr_en_WBID    (reg_wr_en_WBID),
    .fwd_data_WB       (fwd_data_WB),
    .fwd_rd_WB         (fwd_rd_WB),
    .fwd_valid_WB      (fwd_valid_WB),
    .halted            (halted),
    .wr_count          (wr_count),
    .cycle_count       (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] cnt(input logic [31:0] x);
`ifdef WB_PERF_CNT_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  task automatic applyStimulus(input logic [1:0] ctrl, input logic [2:0] f3, input logic [1:0] off,
                               input logic [4:0] rd, input logic en, input logic halt,
                               input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] mem);
    reg_wr_ctrl_MEMWB = ctrl;
    funct3_MEMWB      = f3;
    byte_offset_MEMWB = off;
    rd_MEMWB          = rd;
    reg_wr_en_MEMWB   = en;
    halt_WB           = halt;
    ALU_out_MEMWB     = alu;
    pc_4_MEMWB        = pc4;
    mem_rd_data_MEMWB = mem;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with reset high; the counter model advances from the inputs held across it.
  task automatic step();
    @(posedge clk);
    if (!model_halted) begin
      exp_cyc = exp_cyc + 32'd1;
      if (reg_wr_en_MEMWB && rd_MEMWB != 5'd0) exp_wr = exp_wr + 32'd1;
      if (halt_WB) model_halted = 1'b1;
    end
    #1;
  endtask

  task automatic checkRegsZero(input string tag);
    checkOutput({tag, "_fwd_data"}, fwd_data_WB, 32'd0);
    checkOutput({tag, "_fwd_rd"}, {27'd0, fwd_rd_WB}, 32'd0);
    checkOutput({tag, "_fwd_valid"}, {31'd0, fwd_valid_WB}, 32'd0);
    checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd0);
    checkOutput({tag, "_wr_count"}, wr_count, 32'd0);
    checkOutput({tag, "_cycle_count"}, cycle_count, 32'd0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_wr_count"}, wr_count, cnt(exp_wr));
    checkOutput({tag, "_cycle_count"}, cycle_count, cnt(exp_cyc));
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_wr = '0;
    exp_cyc = '0;
    model_halted = 1'b0;
    reset = 1'b0;

    // Reset held: registers zero, write enable forced low, data path still follows inputs.
    applyStimulus(2'd0, 3'b000, 2'd0, 5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'd0, 32'd0);
    checkRegsZero("reset");
    checkOutput("reset_wr_en_forced", {31'd0, reg_wr_en_WBID}, 32'd0);
    checkOutput("reset_data_follows", reg_wr_data_WBID, 32'h0000_1234);
    checkOutput("reset_rd_follows", {27'd0, rd_WBID}, 32'd5);
    @(posedge clk);
    #1;
    checkOutput("reset_edge_fwd_valid", {31'd0, fwd_valid_WB}, 32'd0);
    applyStimulus(2'd0, 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    checkCounters("idle");

    // Sign-extended byte load from the top byte.
    applyStimulus(2'd2, 3'b000, 2'd3, 5'd5, 1'b1, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lb_off3_data", reg_wr_data_WBID, 32'hFFFF_FF80);
    checkOutput("lb_off3_wr_en", {31'd0, reg_wr_en_WBID}, 32'd1);
    step();
    checkOutput("lb_fwd_rd", {27'd0, fwd_rd_WB}, 32'd5);
    checkOutput("lb_fwd_valid", {31'd0, fwd_valid_WB}, 32'd1);
    checkOutput("lb_fwd_data", fwd_data_WB, 32'hFFFF_FF80);
    checkCounters("lb");

    // Remaining extraction variants, write disabled.
    applyStimulus(2'd2, 3'b101, 2'd2, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lhu_off2", reg_wr_data_WBID, 32'h0000_80FF);
    checkOutput("no_en_wr_en", {31'd0, reg_wr_en_WBID}, 32'd0);
    applyStimulus(2'd2, 3'b001, 2'd2, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lh_off2", reg_wr_data_WBID, 32'hFFFF_80FF);
    applyStimulus(2'd2, 3'b001, 2'd0, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lh_off0", reg_wr_data_WBID, 32'h0000_7F01);
    applyStimulus(2'd2, 3'b100, 2'd1, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lbu_off1", reg_wr_data_WBID, 32'h0000_007F);
    applyStimulus(2'd2, 3'b100, 2'd3, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lbu_off3", reg_wr_data_WBID, 32'h0000_0080);
    applyStimulus(2'd2, 3'b000, 2'd2, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lb_off2", reg_wr_data_WBID, 32'hFFFF_FFFF);
    applyStimulus(2'd2, 3'b010, 2'd3, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("lw", reg_wr_data_WBID, 32'h80FF_7F01);
    applyStimulus(2'd2, 3'b011, 2'd1, 5'd6, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80FF_7F01);
    checkOutput("f3_011_word", reg_wr_data_WBID, 32'h80FF_7F01);
    step();
    checkOutput("hold_fwd_valid", {31'd0, fwd_valid_WB}, 32'd0);
    checkOutput("hold_fwd_data", fwd_data_WB, 32'hFFFF_FF80);
    checkOutput("hold_fwd_rd", {27'd0, fwd_rd_WB}, 32'd5);

    // Source select: PC+4, reserved, ALU.
    applyStimulus(2'd1, 3'b000, 2'd0, 5'd3, 1'b1, 1'b0, 32'h1111_1111, 32'h0000_0104, 32'h2222_2222);
    checkOutput("pc4_data", reg_wr_data_WBID, 32'h0000_0104);
    checkOutput("pc4_rd", {27'd0, rd_WBID}, 32'd3);
    step();
    checkOutput("pc4_fwd_data", fwd_data_WB, 32'h0000_0104);
    checkOutput("pc4_fwd_rd", {27'd0, fwd_rd_WB}, 32'd3);
    checkCounters("pc4");
    applyStimulus(2'd3, 3'b000, 2'd0, 5'd9, 1'b1, 1'b0, 32'h1111_1111, 32'h0000_0104, 32'h2222_2222);
    checkOutput("ctrl3_zero", reg_wr_data_WBID, 32'd0);
    applyStimulus(2'd0, 3'b000, 2'd0, 5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0104, 32'h2222_2222);
    checkOutput("alu_data", reg_wr_data_WBID, 32'hDEAD_BEEF);
    checkOutput("rd0_wr_en", {31'd0, reg_wr_en_WBID}, 32'd0);
    step();
    checkOutput("rd0_fwd_valid", {31'd0, fwd_valid_WB}, 32'd0);
    checkOutput("rd0_fwd_data", fwd_data_WB, 32'h0000_0104);
    checkCounters("rd0");

    // Halt instruction still writes; halted rises on that edge.
    applyStimulus(2'd0, 3'b000, 2'd0, 5'd7, 1'b1, 1'b1, 32'hCAFE_0007, 32'd0, 32'd0);
    checkOutput("halt_wr_en", {31'd0, reg_wr_en_WBID}, 32'd1);
    checkOutput("pre_halt_halted", {31'd0, halted}, 32'd0);
    step();
    checkOutput("halt_halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_fwd_data", fwd_data_WB, 32'hCAFE_0007);
    checkOutput("halt_fwd_rd", {27'd0, fwd_rd_WB}, 32'd7);
    checkOutput("halt_fwd_valid", {31'd0, fwd_valid_WB}, 32'd1);
    checkCounters("halt");

    applyStimulus(2'd0, 3'b000, 2'd0, 5'd4, 1'b1, 1'b0, 32'h0000_0055, 32'd0, 32'd0);
    checkOutput("halted_wr_en", {31'd0, reg_wr_en_WBID}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("halted_sticky", {31'd0, halted}, 32'd1);
    checkOutput("halted_fwd_valid", {31'd0, fwd_valid_WB}, 32'd0);
    checkOutput("halted_fwd_data", fwd_data_WB, 32'hCAFE_0007);
    checkCounters("frozen");

    // Asynchronous reset between edges while halted.
    #3;
    reset = 1'b0;
    #1;
    checkRegsZero("async_reset");
    checkOutput("async_reset_wr_en", {31'd0, reg_wr_en_WBID}, 32'd0);
    exp_wr = '0;
    exp_cyc = '0;
    model_halted = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(2'd0, 3'b000, 2'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    checkOutput("rerun_halted", {31'd0, halted}, 32'd0);
    checkCounters("rerun");
    applyStimulus(2'd0, 3'b000, 2'd0, 5'd2, 1'b1, 1'b0, 32'h0000_0077, 32'd0, 32'd0);
    checkOutput("rerun_wr_en", {31'd0, reg_wr_en_WBID}, 32'd1);
    step();
    checkOutput("rerun_fwd_data", fwd_data_WB, 32'h0000_0077);
    checkCounters("rerun_wr");

`ifdef WB_PERF_CNT_EN
    // Counter wrap: preload the write counter to all ones and do one more write.
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    exp_wr = 32'hFFFF_FFFF;
    step();
    checkOutput("wrap_wr_count", wr_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
